// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocate, out-of-order completion from up to
// three writeback ports, and in-order retirement of up to two entries per cycle.
module reorder_buffer #(
    parameter int DEPTH  = 64,
    parameter int IDX_W  = 6,
    parameter int PC_W   = 12,
    parameter int PREG_W = 6,
    parameter int AREG_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_valid,
    output logic              alloc_ready,
    output logic [IDX_W-1:0]  alloc_idx,
    input  logic [PC_W-1:0]   alloc_pc,
    input  logic              alloc_has_rd,
    input  logic [AREG_W-1:0] alloc_areg,
    input  logic [PREG_W-1:0] alloc_preg,
    input  logic [PREG_W-1:0] alloc_old_preg,
    input  logic              wb0_valid,
    input  logic [IDX_W-1:0]  wb0_rob,
    input  logic [31:0]       wb0_res,
    input  logic              wb1_valid,
    input  logic [IDX_W-1:0]  wb1_rob,
    input  logic [31:0]       wb1_res,
    input  logic              wb2_valid,
    input  logic [IDX_W-1:0]  wb2_rob,
    input  logic [31:0]       wb2_res,
    output logic              ret0_valid,
    output logic [PC_W-1:0]   ret0_pc,
    output logic              ret0_has_rd,
    output logic [AREG_W-1:0] ret0_areg,
    output logic [PREG_W-1:0] ret0_preg,
    output logic [PREG_W-1:0] ret0_old_preg,
    output logic [31:0]       ret0_res,
    output logic              ret1_valid,
    output logic [PC_W-1:0]   ret1_pc,
    output logic              ret1_has_rd,
    output logic [AREG_W-1:0] ret1_areg,
    output logic [PREG_W-1:0] ret1_preg,
    output logic [PREG_W-1:0] ret1_old_preg,
    output logic [31:0]       ret1_res,
    output logic [IDX_W:0]    count,
    output logic              empty
);

    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  done_q;
    logic [PC_W-1:0]   pc_q       [DEPTH];
    logic              has_rd_q   [DEPTH];
    logic [AREG_W-1:0] areg_q     [DEPTH];
    logic [PREG_W-1:0] preg_q     [DEPTH];
    logic [PREG_W-1:0] old_preg_q [DEPTH];
    logic [31:0]       res_q      [DEPTH];

    logic [IDX_W-1:0]  head_q, head_d, tail_q, tail_d, head1;
    logic [IDX_W:0]    count_q, count_d;
    logic              alloc_fire, r0, r1;

    logic [2:0]        wb_valid;
    logic [IDX_W-1:0]  wb_rob [3];
    logic [31:0]       wb_res [3];
    logic [2:0]        wb_ok;

    assign wb_valid  = {wb2_valid, wb1_valid, wb0_valid};
    assign wb_rob[0] = wb0_rob;
    assign wb_rob[1] = wb1_rob;
    assign wb_rob[2] = wb2_rob;
    assign wb_res[0] = wb0_res;
    assign wb_res[1] = wb1_res;
    assign wb_res[2] = wb2_res;

    // Full is judged on registered count only: a same-cycle retire never frees a slot early.
    assign alloc_ready = (count_q != (IDX_W+1)'(DEPTH));
    assign alloc_idx   = tail_q;
    assign alloc_fire  = alloc_valid & alloc_ready;
    assign count       = count_q;
    assign empty       = (count_q == '0);

    assign head1 = head_q + IDX_W'(1);
    assign r0    = busy_q[head_q] & done_q[head_q];
    assign r1    = r0 & busy_q[head1] & done_q[head1];

    assign head_d  = head_q + IDX_W'(r0) + IDX_W'(r1);
    assign tail_d  = tail_q + IDX_W'(alloc_fire);
    assign count_d = count_q + (IDX_W+1)'(alloc_fire) - (IDX_W+1)'(r0) - (IDX_W+1)'(r1);

    // A completion is accepted only for a pending entry; on an index clash the lowest port wins.
    always_comb begin
        wb_ok = '0;
        for (int n = 0; n < 3; n++) begin
            wb_ok[n] = wb_valid[n] & busy_q[wb_rob[n]] & ~done_q[wb_rob[n]];
            for (int m = 0; m < n; m++) begin
                if (wb_valid[m] && (wb_rob[m] == wb_rob[n])) begin
                    wb_ok[n] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (alloc_fire) begin
                busy_q[tail_q] <= 1'b1;
                done_q[tail_q] <= 1'b0;
            end
            for (int n = 0; n < 3; n++) begin
                if (wb_ok[n]) begin
                    done_q[wb_rob[n]] <= 1'b1;
                end
            end
            if (r0) begin
                busy_q[head_q] <= 1'b0;
                done_q[head_q] <= 1'b0;
            end
            if (r1) begin
                busy_q[head1] <= 1'b0;
                done_q[head1] <= 1'b0;
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage carries no reset; busy/done alone define validity.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            pc_q[tail_q]       <= alloc_pc;
            has_rd_q[tail_q]   <= alloc_has_rd;
            areg_q[tail_q]     <= alloc_areg;
            preg_q[tail_q]     <= alloc_preg;
            old_preg_q[tail_q] <= alloc_old_preg;
        end
        for (int n = 0; n < 3; n++) begin
            if (wb_ok[n]) begin
                res_q[wb_rob[n]] <= wb_res[n];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ret0_valid    <= 1'b0;
            ret0_pc       <= '0;
            ret0_has_rd   <= 1'b0;
            ret0_areg     <= '0;
            ret0_preg     <= '0;
            ret0_old_preg <= '0;
            ret0_res      <= '0;
            ret1_valid    <= 1'b0;
            ret1_pc       <= '0;
            ret1_has_rd   <= 1'b0;
            ret1_areg     <= '0;
            ret1_preg     <= '0;
            ret1_old_preg <= '0;
            ret1_res      <= '0;
        end else begin
            ret0_valid <= r0;
            ret1_valid <= r1;
            if (r0) begin
                ret0_pc       <= pc_q[head_q];
                ret0_has_rd   <= has_rd_q[head_q];
                ret0_areg     <= areg_q[head_q];
                ret0_preg     <= preg_q[head_q];
                ret0_old_preg <= old_preg_q[head_q];
                ret0_res      <= res_q[head_q];
            end
            if (r1) begin
                ret1_pc       <= pc_q[head1];
                ret1_has_rd   <= has_rd_q[head1];
                ret1_areg     <= areg_q[head1];
                ret1_preg     <= preg_q[head1];
                ret1_old_preg <= old_preg_q[head1];
                ret1_res      <= res_q[head1];
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: queue scoreboard in program order plus
// a vector table for the basic out-of-order completion sequence and directed corners.
module tb_reorder_buffer;
    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        alloc_valid = 1'b0;
    logic [11:0] alloc_pc = '0;
    logic        alloc_has_rd = 1'b0;
    logic [4:0]  alloc_areg = '0;
    logic [5:0]  alloc_preg = '0, alloc_old_preg = '0;
    logic        wb_v   [3];
    logic [5:0]  wb_rob [3];
    logic [31:0] wb_res [3];

    logic        alloc_ready, empty;
    logic [5:0]  alloc_idx;
    logic [6:0]  count;
    logic        ret0_valid, ret1_valid, ret0_has_rd, ret1_has_rd;
    logic [11:0] ret0_pc, ret1_pc;
    logic [4:0]  ret0_areg, ret1_areg;
    logic [5:0]  ret0_preg, ret1_preg, ret0_old_preg, ret1_old_preg;
    logic [31:0] ret0_res, ret1_res;

    reorder_buffer dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
        .alloc_pc(alloc_pc), .alloc_has_rd(alloc_has_rd), .alloc_areg(alloc_areg),
        .alloc_preg(alloc_preg), .alloc_old_preg(alloc_old_preg),
        .wb0_valid(wb_v[0]), .wb0_rob(wb_rob[0]), .wb0_res(wb_res[0]),
        .wb1_valid(wb_v[1]), .wb1_rob(wb_rob[1]), .wb1_res(wb_res[1]),
        .wb2_valid(wb_v[2]), .wb2_rob(wb_rob[2]), .wb2_res(wb_res[2]),
        .ret0_valid(ret0_valid), .ret0_pc(ret0_pc), .ret0_has_rd(ret0_has_rd),
        .ret0_areg(ret0_areg), .ret0_preg(ret0_preg), .ret0_old_preg(ret0_old_preg),
        .ret0_res(ret0_res),
        .ret1_valid(ret1_valid), .ret1_pc(ret1_pc), .ret1_has_rd(ret1_has_rd),
        .ret1_areg(ret1_areg), .ret1_preg(ret1_preg), .ret1_old_preg(ret1_old_preg),
        .ret1_res(ret1_res),
        .count(count), .empty(empty)
    );

    typedef struct {
        logic [5:0]  idx;
        logic [11:0] pc;
        logic        has_rd;
        logic [4:0]  areg;
        logic [5:0]  preg;
        logic [5:0]  old_preg;
        bit          done;
        logic [31:0] res;
    } ent_t;

    typedef struct {
        bit          av;
        logic [11:0] pc;
        bit          wv;
        logic [5:0]  wrob;
        logic [31:0] wres;
        bit          r0v;
        logic [11:0] r0pc;
        bit          r1v;
        logic [11:0] r1pc;
        int          cnt;
    } vec_t;

    ent_t        sb[$];
    logic [5:0]  m_tail = '0;
    logic [11:0] last_pc0 = '0, last_pc1 = '0;
    int          tests = 0, failed = 0, cyc = 0;
    vec_t        tbl [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clr_in();
        alloc_valid = 1'b0;
        for (int k = 0; k < 3; k++) wb_v[k] = 1'b0;
    endtask

    task automatic set_alloc(input logic [11:0] pc);
        alloc_valid    = 1'b1;
        alloc_pc       = pc;
        alloc_has_rd   = 1'($urandom);
        alloc_areg     = 5'($urandom);
        alloc_preg     = 6'($urandom);
        alloc_old_preg = 6'($urandom);
    endtask

    task automatic set_wb(input int k, input logic [5:0] rob, input logic [31:0] res);
        wb_v[k] = 1'b1; wb_rob[k] = rob; wb_res[k] = res;
    endtask

    // One clock: predict from the pre-edge model, advance, then compare every output.
    task automatic tick();
        ent_t e0, e1, ne;
        bit   r0, r1, fire;
        int   pos[3];
        int   n;
        n = sb.size();
        if (!rst) begin
            chk("alloc_ready", alloc_ready, n < DEPTH);
            chk("alloc_idx", alloc_idx, m_tail);
        end
        fire = !rst && alloc_valid && (n < DEPTH);
        r0 = !rst && (n > 0) && sb[0].done;
        r1 = r0 && (n > 1) && sb[1].done;
        if (r0) e0 = sb[0];
        if (r1) e1 = sb[1];
        for (int k = 0; k < 3; k++) begin
            pos[k] = -1;
            if (!rst && wb_v[k])
                for (int p = 0; p < n; p++)
                    if (sb[p].idx == wb_rob[k] && !sb[p].done) pos[k] = p;
            for (int m = 0; m < k; m++)
                if (wb_v[m] && wb_rob[m] == wb_rob[k]) pos[k] = -1;
        end
        ne.idx = m_tail; ne.pc = alloc_pc; ne.has_rd = alloc_has_rd; ne.areg = alloc_areg;
        ne.preg = alloc_preg; ne.old_preg = alloc_old_preg; ne.done = 1'b0; ne.res = '0;

        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            sb.delete();
            m_tail = '0; last_pc0 = '0; last_pc1 = '0;
        end else begin
            for (int k = 0; k < 3; k++)
                if (pos[k] >= 0) begin
                    sb[pos[k]].done = 1'b1;
                    sb[pos[k]].res  = wb_res[k];
                end
            if (r0) void'(sb.pop_front());
            if (r1) void'(sb.pop_front());
            if (fire) begin
                sb.push_back(ne);
                m_tail = m_tail + 6'd1;
            end
        end

        chk("ret0_valid", ret0_valid, r0);
        if (r0) begin
            chk("ret0_pc", ret0_pc, e0.pc);         chk("ret0_res", ret0_res, e0.res);
            chk("ret0_has_rd", ret0_has_rd, e0.has_rd); chk("ret0_areg", ret0_areg, e0.areg);
            chk("ret0_preg", ret0_preg, e0.preg);   chk("ret0_old_preg", ret0_old_preg, e0.old_preg);
            last_pc0 = e0.pc;
        end else chk("ret0_pc_hold", ret0_pc, last_pc0);
        chk("ret1_valid", ret1_valid, r1);
        if (r1) begin
            chk("ret1_pc", ret1_pc, e1.pc);         chk("ret1_res", ret1_res, e1.res);
            chk("ret1_has_rd", ret1_has_rd, e1.has_rd); chk("ret1_areg", ret1_areg, e1.areg);
            chk("ret1_preg", ret1_preg, e1.preg);   chk("ret1_old_preg", ret1_old_preg, e1.old_preg);
            last_pc1 = e1.pc;
        end else chk("ret1_pc_hold", ret1_pc, last_pc1);
        chk("count", count, sb.size());
        chk("empty", empty, sb.size() == 0);
        $display("[TB] cyc %0d rst=%0b alloc=%0b wb=%0b%0b%0b ret=%0b%0b pc0=%03h pc1=%03h count=%0d",
                 cyc, rst, fire, wb_v[0], wb_v[1], wb_v[2], ret0_valid, ret1_valid,
                 ret0_pc, ret1_pc, count);
    endtask

    task automatic do_reset();
        clr_in();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        bit seen5;
        for (int k = 0; k < 3; k++) begin
            wb_v[k] = 1'b0; wb_rob[k] = '0; wb_res[k] = '0;
        end
        do_reset();
        chk("reset_alloc_idx", alloc_idx, 6'd0);
        chk("reset_ret0_pc", ret0_pc, 12'h000);

        // Out-of-order completion of three entries, retired in order two per cycle.
        tbl[0] = '{1, 12'h010, 0, 6'd0, 32'h0,      0, 12'h000, 0, 12'h000, 1};
        tbl[1] = '{1, 12'h014, 0, 6'd0, 32'h0,      0, 12'h000, 0, 12'h000, 2};
        tbl[2] = '{1, 12'h018, 0, 6'd0, 32'h0,      0, 12'h000, 0, 12'h000, 3};
        tbl[3] = '{0, 12'h000, 1, 6'd2, 32'h2222,   0, 12'h000, 0, 12'h000, 3};
        tbl[4] = '{0, 12'h000, 1, 6'd1, 32'h1111,   0, 12'h000, 0, 12'h000, 3};
        tbl[5] = '{0, 12'h000, 1, 6'd0, 32'h0F0F,   0, 12'h000, 0, 12'h000, 3};
        tbl[6] = '{0, 12'h000, 0, 6'd0, 32'h0,      1, 12'h010, 1, 12'h014, 1};
        tbl[7] = '{0, 12'h000, 0, 6'd0, 32'h0,      1, 12'h018, 0, 12'h000, 0};
        tbl[8] = '{0, 12'h000, 0, 6'd0, 32'h0,      0, 12'h000, 0, 12'h000, 0};
        for (int i = 0; i < 9; i++) begin
            clr_in();
            if (tbl[i].av) set_alloc(tbl[i].pc);
            if (tbl[i].wv) set_wb(0, tbl[i].wrob, tbl[i].wres);
            tick();
            chk("vec_ret0_valid", ret0_valid, tbl[i].r0v);
            if (tbl[i].r0v) chk("vec_ret0_pc", ret0_pc, tbl[i].r0pc);
            chk("vec_ret1_valid", ret1_valid, tbl[i].r1v);
            if (tbl[i].r1v) chk("vec_ret1_pc", ret1_pc, tbl[i].r1pc);
            chk("vec_count", count, tbl[i].cnt);
        end

        // Full: ignored allocations, and retire frees a slot only from the next cycle.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            set_alloc(12'h100 + 12'(i));
            tick();
        end
        chk("full_count", count, 7'd64);
        chk("full_ready", alloc_ready, 1'b0);
        set_alloc(12'h1FF);
        tick();
        tick();
        chk("full_tail", alloc_idx, 6'd0);
        set_wb(0, 6'd0, 32'hC0DE);
        tick();
        wb_v[0] = 1'b0;
        chk("full_ready_wb", alloc_ready, 1'b0);
        tick();
        chk("full_count_ret", count, 7'd63);
        chk("full_ready_ret", alloc_ready, 1'b1);
        tick();
        chk("full_refill", count, 7'd64);

        // Two ports hitting the same index in one cycle: port 0 wins.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_alloc(12'h200 + 12'(i));
            tick();
        end
        clr_in();
        set_wb(0, 6'd0, 32'h500); set_wb(1, 6'd1, 32'h501); set_wb(2, 6'd2, 32'h502); tick();
        set_wb(0, 6'd3, 32'h503); set_wb(1, 6'd4, 32'h504); set_wb(2, 6'd6, 32'h506); tick();
        set_wb(0, 6'd5, 32'hAAAA); set_wb(1, 6'd7, 32'h507); set_wb(2, 6'd5, 32'hBBBB); tick();
        clr_in();
        seen5 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ret0_valid && ret0_pc == 12'h205) begin chk("dup_res0", ret0_res, 32'hAAAA); seen5 = 1'b1; end
            if (ret1_valid && ret1_pc == 12'h205) begin chk("dup_res1", ret1_res, 32'hAAAA); seen5 = 1'b1; end
        end
        chk("dup_retired", seen5, 1'b1);

        // Stale writeback to an idle index must not pre-complete a later allocation.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_alloc(12'h400 + 12'(i));
            tick();
        end
        clr_in();
        set_wb(0, 6'd9, 32'h1234);
        tick();
        clr_in();
        for (int i = 5; i < 12; i++) begin
            set_alloc(12'h400 + 12'(i));
            tick();
        end
        clr_in();
        for (int i = 0; i < 9; i += 3) begin
            set_wb(0, 6'(i), 32'h4000 + 32'(i));
            set_wb(1, 6'(i + 1), 32'h4001 + 32'(i));
            set_wb(2, 6'(i + 2), 32'h4002 + 32'(i));
            tick();
        end
        clr_in();
        for (int i = 0; i < 8; i++) tick();
        chk("stale_count", count, 7'd3);

        // Wrap: head at 63, second retire slot comes from index 0.
        do_reset();
        for (int i = 0; i < 63; i++) begin
            set_alloc(12'h300 + 12'(i));
            tick();
        end
        clr_in();
        for (int i = 0; i < 63; i += 3) begin
            set_wb(0, 6'(i), 32'h3000 + 32'(i));
            set_wb(1, 6'(i + 1), 32'h3001 + 32'(i));
            set_wb(2, 6'(i + 2), 32'h3002 + 32'(i));
            tick();
        end
        clr_in();
        for (int i = 0; i < 40; i++) tick();
        chk("wrap_tail63", alloc_idx, 6'd63);
        set_alloc(12'h3F0); tick();
        set_alloc(12'h3F1); tick();
        clr_in();
        set_wb(0, 6'd63, 32'h6363); set_wb(1, 6'd0, 32'h0000_0A0A); tick();
        clr_in();
        tick();
        chk("wrap_ret0_pc", ret0_pc, 12'h3F0);
        chk("wrap_ret1_pc", ret1_pc, 12'h3F1);
        chk("wrap_ret1_res", ret1_res, 32'h0000_0A0A);
        chk("wrap_empty", empty, 1'b1);
        chk("wrap_tail", alloc_idx, 6'd1);

        // Reset with work in flight discards everything on that edge.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            set_alloc(12'h500 + 12'(i));
            tick();
        end
        clr_in();
        set_wb(0, 6'd2, 32'h52); set_wb(1, 6'd3, 32'h53); set_wb(2, 6'd5, 32'h55); tick();
        set_alloc(12'h5AA);
        set_wb(0, 6'd0, 32'h50); set_wb(1, 6'd1, 32'h51); set_wb(2, 6'd4, 32'h54);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clr_in();
        chk("rst_count", count, 7'd0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_ret0_valid", ret0_valid, 1'b0);
        chk("rst_ret1_valid", ret1_valid, 1'b0);
        chk("rst_alloc_idx", alloc_idx, 6'd0);
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular reorder buffer directly downstream of result_buffer.
- Allocates one entry per cycle at dispatch, in program order.
- Accepts up to three registered completions per cycle, tagged by ROB index (the rob0_..rob2_ / res0_..res2_ / valid0_..valid2_ outputs of result_buffer).
- Retires up to two completed entries per cycle strictly in order, presenting architectural commit info to the rename map / free list and the architectural register file.

Parameters:
- DEPTH, 64, number of entries; must be a power of two.
- IDX_W, 6, log2(DEPTH); ROB index width.
- PC_W, 12, instruction PC width.
- PREG_W, 6, physical register tag width.
- AREG_W, 5, architectural register index width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- alloc_valid  input  1  dispatch requests an entry this cycle.
- alloc_ready  output  1  combinational; 1 when count < DEPTH.
- alloc_idx  output  IDX_W  combinational; current tail index, assigned to the requesting instruction.
- alloc_pc  input  PC_W  PC of the dispatched instruction.
- alloc_has_rd  input  1  instruction writes a destination register.
- alloc_areg  input  AREG_W  architectural destination register.
- alloc_preg  input  PREG_W  newly renamed physical destination.
- alloc_old_preg  input  PREG_W  previous mapping of areg, freed at retire.
- wbN_valid  input  1  (N=0..2) completion valid.
- wbN_rob  input  IDX_W  (N=0..2) completing entry index.
- wbN_res  input  32  (N=0..2) result value.
- retM_valid  output  1  (M=0..1) registered; entry retired this cycle.
- retM_pc  output  PC_W  (M=0..1) registered; retired PC.
- retM_has_rd, retM_areg, retM_preg, retM_old_preg  output  1/AREG_W/PREG_W/PREG_W  (M=0..1) registered; commit mapping.
- retM_res  output  32  (M=0..1) registered; retired result.
- count  output  IDX_W+1  registered; number of occupied entries.
- empty  output  1  combinational; count == 0.

Behaviour:
- State:
  - Per entry: busy, done, pc, has_rd, areg, preg, old_preg, res.
  - head and tail pointers, IDX_W bits each, wrap modulo DEPTH.
  - count, IDX_W+1 bits.
- Reset:
  - head=0, tail=0, count=0.
  - All busy=0 and done=0.
  - Every ret* output = 0.
  - Entry payload fields are not reset.
- Allocate (alloc_valid & alloc_ready):
  - entry[tail] gets busy=1, done=0 and the payload from the alloc_* inputs.
  - tail advances by 1; DEPTH-1 wraps to 0.
  - alloc_valid while not ready is ignored; no state change.
- Writeback, for each N with wbN_valid:
  - If entry[wbN_rob] was busy and not done before the edge: set done=1 and res=wbN_res.
  - Otherwise ignore (stale or duplicate).
  - Several ports naming the same index in one cycle: lowest N wins.
- Retire, evaluated on pre-edge state:
  - r0 = busy[head] & done[head].
  - r1 = r0 & busy[head+1] & done[head+1].
  - On the edge: retM_valid <= rM, and the payload is copied into retM_*.
  - Each retired entry's busy and done are cleared; head advances by r0+r1.
  - When rM=0, retM_valid <= 0 and retM payload outputs hold their previous value.
- Latency:
  - A writeback at edge k is retired at edge k+1 at the earliest; ret outputs are visible after k+1.
  - There is no writeback-to-retire bypass in the same cycle.
- count_next = count + alloc_fire − (r0 + r1).
- Full case:
  - alloc_ready is 0 when count == DEPTH, even if retirement frees entries this cycle.
  - Retirement does not credit allocation in the same cycle.
- Empty case: r0 = r1 = 0; ret outputs go invalid.
- A writeback to an index allocated in the same cycle is ignored, because that entry was not busy pre-edge.
- A retire-second at index DEPTH-1 wraps to 0 for head+1.
- Reset asserted mid-operation discards all in-flight entries on that edge; there is no partial retire.

Test Plan:
- Allocate indices 0,1,2 (pc 0x010,0x014,0x018), writeback 2 then 1 then 0 on consecutive cycles -> no retire until index 0 is done; the cycle after that, ret0=pc 0x010, ret1=pc 0x014; next cycle ret0=pc 0x018, ret1_valid=0; count returns to 0.
- Fill 64 entries -> alloc_ready=0, count=64; further alloc_valid is ignored (tail stays 0). Complete index 0 -> after retire, count=63 and alloc_ready=1 the following cycle, not before.
- Same cycle wb0_rob=5 res=0xAAAA and wb2_rob=5 res=0xBBBB -> entry 5 retires with res 0xAAAA.
- Writeback to a non-busy index 9 with res 0x1234 -> no state change; a later allocation at index 9 still starts with done=0.
- Wrap: head=63, tail=1, both entries done -> ret0 from index 63, ret1 from index 0; head=1, empty=1.
- Assert rst with 10 entries in flight, some done -> next cycle count=0, empty=1, all ret*_valid=0, alloc_idx=0.
